// File: rtl/y_pkg.sv
// Shared constants and the instruction decoder for the y decode stage.
// ALU op, opcode and funct encodings follow the MIPS subset the ALU implements.
package y_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic                 legal;
    alu_op_e              op;
    logic                 b_imm;
    logic [REG_IDX_W-1:0] rd;
    logic                 wen;
    logic                 branch;
  } dec_t;

  function automatic dec_t decode_ins(input logic [31:0] ins);
    dec_t d;
    d.legal  = 1'b0;
    d.op     = OP_AND;
    d.b_imm  = 1'b0;
    d.rd     = '0;
    d.wen    = 1'b0;
    d.branch = 1'b0;
    case (ins[31:26])
      OPC_RTYPE: begin
        d.legal = 1'b1;
        d.wen   = 1'b1;
        d.rd    = ins[15:11];
        case (ins[5:0])
          FN_AND:  d.op = OP_AND;
          FN_OR:   d.op = OP_OR;
          FN_ADD:  d.op = OP_ADD;
          FN_SUB:  d.op = OP_SUB;
          FN_SLT:  d.op = OP_SLT;
          default: begin
            d.legal = 1'b0;
            d.wen   = 1'b0;
          end
        endcase
      end
      OPC_ADDI: begin
        d.legal = 1'b1;
        d.op    = OP_ADD;
        d.b_imm = 1'b1;
        d.rd    = ins[20:16];
        d.wen   = 1'b1;
      end
      OPC_BEQ: begin
        d.legal  = 1'b1;
        d.op     = OP_SUB;
        d.branch = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/y_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero, and same-cycle write-to-read bypass.
module y_reg_file
  import y_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ra_addr,
  input  logic [REG_IDX_W-1:0] rb_addr,
  output logic [W-1:0]         ra_data,
  output logic [W-1:0]         rb_data,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [W-1:0]         wd
);

  logic [W-1:0] mem_q [NREG];
  logic [W-1:0] mem_d [NREG];
  logic         wr_ok;

  assign wr_ok = we && (wa != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wa] = wd;
  end

  // A write landing this cycle is forwarded so the reader never sees stale data.
  always_comb begin
    ra_data = mem_q[ra_addr];
    rb_data = mem_q[rb_addr];
    if (wr_ok && (wa == ra_addr)) ra_data = wd;
    if (wr_ok && (wa == rb_addr)) rb_data = wd;
    if (ra_addr == '0) ra_data = '0;
    if (rb_addr == '0) rb_data = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/y_decode_stage.sv
// Instruction decode stage: reads operands, decodes the ALU op and holds one
// output slot under valid/ready, refreshing held operands on late writebacks.
module y_decode_stage
  import y_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          ins,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [W-1:0]         wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_a,
  output logic [W-1:0]         out_b,
  output logic [2:0]           out_op,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wen,
  output logic                 out_branch,
  output logic                 illegal
);

  dec_t                 dec;
  logic [REG_IDX_W-1:0] rs, rt;
  logic [W-1:0]         rs_val, rt_val, imm_ext;
  logic                 accept, wb_hit;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_a_q, out_a_d, out_b_q, out_b_d;
  alu_op_e              out_op_q, out_op_d;
  logic [REG_IDX_W-1:0] out_rd_q, out_rd_d;
  logic                 out_wen_q, out_wen_d, out_branch_q, out_branch_d;
  logic                 illegal_q, illegal_d;
  logic [REG_IDX_W-1:0] held_rs_q, held_rs_d, held_rt_q, held_rt_d;
  logic                 b_from_rt_q, b_from_rt_d;

  assign dec     = decode_ins(ins);
  assign rs      = ins[25:21];
  assign rt      = ins[20:16];
  assign imm_ext = {{(W-16){ins[15]}}, ins[15:0]};

  y_reg_file #(.W(W), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rs_val),
    .rb_data (rt_val),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_addr != '0);

  // A new legal word always wins over draining or refreshing the held slot.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_op_d     = out_op_q;
    out_rd_d     = out_rd_q;
    out_wen_d    = out_wen_q;
    out_branch_d = out_branch_q;
    held_rs_d    = held_rs_q;
    held_rt_d    = held_rt_q;
    b_from_rt_d  = b_from_rt_q;
    illegal_d    = illegal_q || (accept && !dec.legal);
    if (accept && dec.legal) begin
      out_valid_d  = 1'b1;
      out_a_d      = rs_val;
      out_b_d      = dec.b_imm ? imm_ext : rt_val;
      out_op_d     = dec.op;
      out_rd_d     = dec.rd;
      out_wen_d    = dec.wen;
      out_branch_d = dec.branch;
      held_rs_d    = rs;
      held_rt_d    = rt;
      b_from_rt_d  = !dec.b_imm;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && wb_hit) begin
      if (wb_addr == held_rs_q) out_a_d = wb_data;
      if (b_from_rt_q && (wb_addr == held_rt_q)) out_b_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_op_q     <= OP_AND;
      out_rd_q     <= '0;
      out_wen_q    <= 1'b0;
      out_branch_q <= 1'b0;
      illegal_q    <= 1'b0;
      held_rs_q    <= '0;
      held_rt_q    <= '0;
      b_from_rt_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_op_q     <= out_op_d;
      out_rd_q     <= out_rd_d;
      out_wen_q    <= out_wen_d;
      out_branch_q <= out_branch_d;
      illegal_q    <= illegal_d;
      held_rs_q    <= held_rs_d;
      held_rt_q    <= held_rt_d;
      b_from_rt_q  <= b_from_rt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_op     = out_op_q;
  assign out_rd     = out_rd_q;
  assign out_wen    = out_wen_q;
  assign out_branch = out_branch_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_y_decode_stage.sv
// Bench for y_decode_stage: a directed vector table, a mid-cycle reset sequence,
// and a randomized run compared against a behavioural model of the stage.
module tb_y_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ins;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_branch;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  y_decode_stage #(.W(32), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ins        (ins),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_op     (out_op),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_branch (out_branch),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: architectural registers plus the one output slot.
  logic [31:0] m_regs [32];
  logic        m_v, m_wen, m_br, m_ill, m_b_rt;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd, m_hrs, m_hrt;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] readReg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_v = 0; m_wen = 0; m_br = 0; m_ill = 0; m_b_rt = 0;
    m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_hrs = 0; m_hrt = 0;
  endtask

  // Evaluates one clock edge from the inputs currently driven.
  task automatic modelEdge();
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt;
    logic        legal, acc, wen, br, b_rt;
    logic [2:0]  op;
    logic [4:0]  dst;
    logic [31:0] a, b;
    opc = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
    legal = 0; op = 0; dst = 0; wen = 0; br = 0; b_rt = 1;
    a = readReg(rs); b = readReg(rt);
    if (opc == 6'h00) begin
      legal = 1; dst = ins[15:11]; wen = 1;
      if (fn == 6'h24) op = 3'b000;
      else if (fn == 6'h25) op = 3'b001;
      else if (fn == 6'h20) op = 3'b010;
      else if (fn == 6'h22) op = 3'b110;
      else if (fn == 6'h2A) op = 3'b111;
      else legal = 0;
    end else if (opc == 6'h08) begin
      legal = 1; op = 3'b010; dst = rt; wen = 1; b_rt = 0;
      b = 32'($signed(ins[15:0]));
    end else if (opc == 6'h04) begin
      legal = 1; op = 3'b110; br = 1;
    end
    acc = in_valid && (!m_v || out_ready);
    if (acc && !legal) m_ill = 1;
    if (acc && legal) begin
      m_v = 1; m_a = a; m_b = b; m_op = op; m_rd = dst; m_wen = wen; m_br = br;
      m_hrs = rs; m_hrt = rt; m_b_rt = b_rt;
    end else if (out_ready) begin
      m_v = 0;
    end else if (m_v && wb_en && wb_addr != 0) begin
      if (wb_addr == m_hrs) m_a = wb_data;
      if (m_b_rt && wb_addr == m_hrt) m_b = wb_data;
    end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] word, input logic ordy,
                               input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    in_valid = iv; ins = word; out_ready = ordy;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("rnd.out_valid", 32'(out_valid), 32'(m_v));
    checkOne("rnd.in_ready", 32'(in_ready), 32'(!m_v || out_ready));
    checkOne("rnd.illegal", 32'(illegal), 32'(m_ill));
    if (m_v) begin
      checkOne("rnd.out_a", out_a, m_a);
      checkOne("rnd.out_b", out_b, m_b);
      checkOne("rnd.out_op", 32'(out_op), 32'(m_op));
      checkOne("rnd.out_rd", 32'(out_rd), 32'(m_rd));
      checkOne("rnd.out_wen", 32'(out_wen), 32'(m_wen));
      checkOne("rnd.out_branch", 32'(out_branch), 32'(m_br));
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        ordy;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  eop;
    logic [4:0]  erd;
    logic        ewen;
    logic        ebr;
    logic        erdy;
    logic        eill;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [5:0] fns [5];
    fns[0] = 6'h24; fns[1] = 6'h25; fns[2] = 6'h20; fns[3] = 6'h22; fns[4] = 6'h2A;

    // Columns: iv ins ordy wbe wba wbd | valid a b op rd wen branch in_ready illegal
    vt[0]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd5, 32'd7, 3'b010, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, itype(6'h08, 5'd0, 5'd4, 16'hFFFD), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'hFFFF_FFFD, 3'b010, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, itype(6'h04, 5'd1, 5'd1, 16'h0000), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd5, 32'd5, 3'b110, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, rtype(5'd1, 5'd2, 5'd5, 6'h22), 1'b1, 1'b1, 5'd1, 32'd9, 1'b1, 32'd9, 32'd7, 3'b110, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, rtype(5'd0, 5'd0, 5'd7, 6'h20), 1'b1, 1'b1, 5'd0, 32'd55, 1'b1, 32'd0, 32'd0, 3'b010, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b1, rtype(5'd1, 5'd2, 5'd6, 6'h2A), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 32'd9, 32'd7, 3'b111, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, rtype(5'd1, 5'd2, 5'd8, 6'h24), 1'b0, 1'b1, 5'd2, 32'd100, 1'b1, 32'd9, 32'd100, 3'b111, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, rtype(5'd1, 5'd2, 5'd9, 6'h25), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd9, 32'd100, 3'b001, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, rtype(5'd2, 5'd1, 5'd10, 6'h20), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'd100, 32'd9, 3'b010, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[14] = '{1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 0; ins = 0; out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
    modelReset();
    #12;
    checkOne("reset.out_valid", 32'(out_valid), 32'd0);
    checkOne("reset.out_a", out_a, 32'd0);
    checkOne("reset.out_b", out_b, 32'd0);
    checkOne("reset.out_op", 32'(out_op), 32'd0);
    checkOne("reset.out_rd", 32'(out_rd), 32'd0);
    checkOne("reset.out_wen", 32'(out_wen), 32'd0);
    checkOne("reset.out_branch", 32'(out_branch), 32'd0);
    checkOne("reset.illegal", 32'(illegal), 32'd0);
    checkOne("reset.in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vt[i].iv, vt[i].ins, vt[i].ordy, vt[i].wbe, vt[i].wba, vt[i].wbd);
      checkOne($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      checkOne($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].erdy));
      checkOne($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vt[i].eill));
      if (vt[i].ev) begin
        checkOne($sformatf("vec%0d.out_a", i), out_a, vt[i].ea);
        checkOne($sformatf("vec%0d.out_b", i), out_b, vt[i].eb);
        checkOne($sformatf("vec%0d.out_op", i), 32'(out_op), 32'(vt[i].eop));
        checkOne($sformatf("vec%0d.out_rd", i), 32'(out_rd), 32'(vt[i].erd));
        checkOne($sformatf("vec%0d.out_wen", i), 32'(out_wen), 32'(vt[i].ewen));
        checkOne($sformatf("vec%0d.out_branch", i), 32'(out_branch), 32'(vt[i].ebr));
      end
    end

    // Mid-cycle reset with a held beat and the sticky illegal flag set.
    applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b0, 5'd0, 32'd0);
    checkOne("hold.out_valid", 32'(out_valid), 32'd1);
    checkOne("hold.out_a", out_a, 32'd9);
    #2 rst = 1'b1;
    #1;
    checkOne("async_rst.out_valid", 32'(out_valid), 32'd0);
    checkOne("async_rst.illegal", 32'(illegal), 32'd0);
    checkOne("async_rst.out_a", out_a, 32'd0);
    modelReset();
    #2 rst = 1'b0;
    applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 5'd0, 32'd0);
    checkOne("post_rst.out_valid", 32'(out_valid), 32'd1);
    checkOne("post_rst.out_a", out_a, 32'd0);
    checkOne("post_rst.out_b", out_b, 32'd0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] word;
      int          kind;
      logic [4:0]  rs, rt, rd;
      kind = $urandom_range(0, 39);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      if (kind < 24)       word = rtype(rs, rt, rd, fns[$urandom_range(0, 4)]);
      else if (kind < 31)  word = itype(6'h08, rs, rt, 16'($urandom));
      else if (kind < 38)  word = itype(6'h04, rs, rt, 16'($urandom));
      else if (kind == 38) word = itype(6'h23, rs, rt, 16'($urandom));
      else                 word = rtype(rs, rt, rd, 6'h21);
      applyStimulus(1'($urandom_range(0, 3) != 0), word, 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      checkOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y_decode_stage.md
# y_decode_stage

Instruction-decode stage that sits directly upstream of the 32-bit ALU. It accepts one instruction word per cycle over a valid/ready handshake and decodes it. It reads two source registers from an internal 32×32 register file that has a same-cycle writeback bypass. It registers the ALU operands `a` and `b`, the 3-bit ALU `op`, and destination/control fields into one output pipeline slot, also under valid/ready.

## Interface
Parameters:
- `W`, 32: datapath width. Only 32 is supported.
- `NREG`, 32: register count. Index width is 5.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  stage can accept this cycle.
- `ins`  in  32  MIPS-format instruction.
- `wb_en`  in  1  register writeback strobe.
- `wb_addr`  in  5  writeback register index.
- `wb_data`  in  32  writeback value.
- `out_valid`  out  1  decoded operands held.
- `out_ready`  in  1  ALU side consumes this cycle.
- `out_a`  out  32  ALU operand a.
- `out_b`  out  32  ALU operand b.
- `out_op`  out  3  ALU op.
- `out_rd`  out  5  destination index.
- `out_wen`  out  1  result is to be written back.
- `out_branch`  out  1  beq; the consumer uses the ALU zero flag.
- `illegal`  out  1  sticky flag; unsupported opcode or funct seen.

## Operation
- ALU op encoding: AND 3'b000, OR 3'b001, ADD 3'b010, SUB 3'b110, SLT 3'b111.
- R-type (`ins[31:26]`=0): funct 0x24→AND, 0x25→OR, 0x20→ADD, 0x22→SUB, 0x2A→SLT.
  - a=R[rs], b=R[rt], rd=`ins[15:11]`, wen=1.
- addi (opcode 0x08): op=ADD, a=R[rs], b=sign-extended `ins[15:0]`, rd=rt, wen=1.
- beq (opcode 0x04): op=SUB, a=R[rs], b=R[rt], rd=0, wen=0, branch=1.
- Any other opcode or funct: the word is accepted but produces no output beat. `illegal` sets to 1 and stays set until `rst`.
- Register 0 reads as 0. Writebacks to index 0 are ignored.
- Bypass: when `wb_en` and `wb_addr`≠0 match rs or rt in the accept cycle, the captured operand is `wb_data`.
- Held-operand refresh: while `out_valid` and not `out_ready`, a writeback to the held rs (nonzero) replaces `out_a`. A writeback to the held rt (nonzero, when b came from rt) replaces `out_b`. The held rs, rt and b-source are stored internally for this purpose.

## Timing
- Reset: `out_valid`=0, `out_a`=`out_b`=0, `out_op`=0, `out_rd`=0, `out_wen`=0, `out_branch`=0, `illegal`=0, all registers=0.
- `in_ready` = !`out_valid` | `out_ready` (combinational).
- Accept happens on `in_valid`&`in_ready`. For a legal word, `out_valid`=1 on the next edge. Latency is 1 cycle and throughput is 1 per cycle.
- When `out_ready` is high and there is no legal accept, `out_valid` clears on the next edge.
- Outputs are stable while `out_valid`&!`out_ready`, except for held-operand refresh.
- Register-file write takes effect on the `wb_en` edge. Bypass covers a read in that same cycle.
- Simultaneous consume and accept: the slot reloads with no bubble.
- Refresh and reload in the same cycle: the new instruction's values win, with bypass applied.
- Reset asserted mid-operation clears the held slot immediately. The in-flight word is lost.

## Structure
- Shared package `y_pkg`:
  - ALU op constants (`OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`).
  - Opcode constants (`OPC_RTYPE`, `OPC_ADDI`, `OPC_BEQ`).
  - Funct constants.
  - Register-index width.
- Sub-module `y_reg_file`: 32×32, two asynchronous read ports, one synchronous write port, r0 hard zero, write-to-read bypass.
- Decode, handshake and refresh logic stay in the top module.

## Test plan
- Reset, then R1←5 and R2←7 by writeback. Issue add r3,r1,r2 → next cycle `out_a`=5, `out_b`=7, `out_op`=010, `out_rd`=3, `out_wen`=1.
- addi r4,r0,-3 → `out_a`=0, `out_b`=32'hFFFF_FFFD, op=010, `out_rd`=4. Then beq r1,r1 → op=110, `out_branch`=1, `out_wen`=0.
- In the accept cycle of sub r5,r1,r2, drive `wb_en`=1 with `wb_addr`=1 and `wb_data`=9 → `out_a`=9. A writeback to r0 leaves reads of r0 at 0.
- Hold `out_ready`=0 with slr r6,r1,r2 held and issue writeback r2←100 → `out_b` becomes 100 and `in_ready`=0. Release `out_ready` → a back-to-back stream gives one beat per cycle.
- Opcode 0x23 → no output beat and `illegal`=1 persists. Assert `rst` while `out_valid`=1 → `out_valid` and `illegal` clear asynchronously.
